// File: rtl/ps2_rx_if.sv
// Decoded-key output bundle of the PS/2 receiver.
// The receiver drives it through the master modport; the key decoder reads it through the slave modport.
interface ps2_rx_if;
  logic [7:0] code;
  logic       code_valid;
  logic       is_break;
  logic       is_extended;
  logic       frame_err;

  modport master (output code, code_valid, is_break, is_extended, frame_err);
  modport slave  (input  code, code_valid, is_break, is_extended, frame_err);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver.
// Synchronizes and glitch-filters the raw pins, then deframes the 11-bit frame:
// start bit, 8 data bits LSB first, odd parity, stop bit.
// E0/F0 prefixes become flags on the next delivered scan code.
// Each good scan code is delivered with a one-cycle code_valid strobe.
// Parity, stop and timeout errors produce a one-cycle frame_err strobe.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic     CLOCK_50,
  input  logic     reset,
  input  logic     PS2_CLK,
  input  logic     PS2_DAT,
  ps2_rx_if.master rx
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0]      FLT_MAX = 8'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  // Odd parity across the data byte and the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  logic [1:0]      clk_sync_r;
  logic [1:0]      dat_sync_r;
  logic            fclk_r;
  logic            fclk_d_r;
  logic [7:0]      flt_cnt_r;
  logic [1:0]      state_r;
  logic [2:0]      bit_cnt_r;
  logic [7:0]      shift_r;
  logic            par_r;
  logic [TO_W-1:0] to_cnt_r;
  logic            ext_pend_r;
  logic            brk_pend_r;
  logic [7:0]      code_r;
  logic            code_valid_r;
  logic            is_break_r;
  logic            is_extended_r;
  logic            frame_err_r;

  logic            fall_s;
  logic            dat_s;
  logic            timeout_s;
  logic            frame_ok_s;

  // Two-flop synchronizers for both asynchronous pins; the idle bus level is high.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_sync_r <= 2'b11;
      dat_sync_r <= 2'b11;
    end else begin
      clk_sync_r <= {clk_sync_r[0], PS2_CLK};
      dat_sync_r <= {dat_sync_r[0], PS2_DAT};
    end
  end

  // Clock filter: fclk flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      fclk_r    <= 1'b1;
      fclk_d_r  <= 1'b1;
      flt_cnt_r <= 8'd0;
    end else begin
      fclk_d_r <= fclk_r;
      if (clk_sync_r[1] != fclk_r) begin
        if (flt_cnt_r == FLT_MAX) begin
          fclk_r    <= ~fclk_r;
          flt_cnt_r <= 8'd0;
        end else begin
          flt_cnt_r <= flt_cnt_r + 8'd1;
        end
      end else begin
        flt_cnt_r <= 8'd0;
      end
    end
  end

  // Fall event, sampled data bit, timeout condition and end-of-frame check.
  always_comb begin
    fall_s     = fclk_d_r & ~fclk_r;
    dat_s      = dat_sync_r[1];
    timeout_s  = (state_r != ST_IDLE) && (to_cnt_r == TO_MAX);
    frame_ok_s = dat_s && odd_parity_ok(shift_r, par_r);
  end

  // In-frame idle counter: held at zero in IDLE, cleared on every fall and on expiry.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      to_cnt_r <= '0;
    end else if ((state_r == ST_IDLE) || fall_s || timeout_s) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + 1'b1;
    end
  end

  // Deframing FSM, prefix folding and registered output strobes.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      bit_cnt_r     <= 3'd0;
      shift_r       <= 8'h00;
      par_r         <= 1'b0;
      ext_pend_r    <= 1'b0;
      brk_pend_r    <= 1'b0;
      code_r        <= 8'h00;
      code_valid_r  <= 1'b0;
      is_break_r    <= 1'b0;
      is_extended_r <= 1'b0;
      frame_err_r   <= 1'b0;
    end else begin
      code_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      if (fall_s) begin
        // A fall always takes priority over an expiring timeout.
        case (state_r)
          ST_IDLE: begin
            if (!dat_s) begin
              state_r   <= ST_DATA;
              bit_cnt_r <= 3'd0;
            end
          end
          ST_DATA: begin
            shift_r   <= {dat_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_r   <= dat_s;
            state_r <= ST_STOP;
          end
          ST_STOP: begin
            state_r <= ST_IDLE;
            if (frame_ok_s) begin
              if (shift_r == PFX_EXT) begin
                ext_pend_r <= 1'b1;
              end else if (shift_r == PFX_BRK) begin
                brk_pend_r <= 1'b1;
              end else begin
                code_r        <= shift_r;
                is_break_r    <= brk_pend_r;
                is_extended_r <= ext_pend_r;
                code_valid_r  <= 1'b1;
                ext_pend_r    <= 1'b0;
                brk_pend_r    <= 1'b0;
              end
            end else begin
              frame_err_r <= 1'b1;
              ext_pend_r  <= 1'b0;
              brk_pend_r  <= 1'b0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end else if (timeout_s) begin
        state_r     <= ST_IDLE;
        bit_cnt_r   <= 3'd0;
        shift_r     <= 8'h00;
        frame_err_r <= 1'b1;
        ext_pend_r  <= 1'b0;
        brk_pend_r  <= 1'b0;
      end
    end
  end

  assign rx.code        = code_r;
  assign rx.code_valid  = code_valid_r;
  assign rx.is_break    = is_break_r;
  assign rx.is_extended = is_extended_r;
  assign rx.frame_err   = frame_err_r;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: directed and randomized PS/2 frames checked against a key-event model.
`timescale 1ns/1ns
module tb_ps2_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 400;
  localparam int HALF           = 20;

  logic CLOCK_50 = 1'b0;
  logic reset;
  logic PS2_CLK;
  logic PS2_DAT;

  ps2_rx_if rx_bus();

  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .PS2_CLK  (PS2_CLK),
    .PS2_DAT  (PS2_DAT),
    .rx       (rx_bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int  vectors     = 0;
  int  miscompares = 0;
  int  cv_total    = 0;
  int  fe_total    = 0;
  int  both_total  = 0;
  time t_cv        = 0;
  time t_fe        = 0;
  time t_fall      = 0;

  // Model of what the key decoder should have seen.
  logic [7:0] m_code;
  bit         m_isb;
  bit         m_ise;
  bit         m_brk;
  bit         m_ext;

  // Strobe monitor, sampled on the falling system clock edge.
  always @(negedge CLOCK_50) begin
    if (rx_bus.code_valid === 1'b1) begin
      cv_total <= cv_total + 1;
      t_cv     <= $time;
    end
    if (rx_bus.frame_err === 1'b1) begin
      fe_total <= fe_total + 1;
      t_fe     <= $time;
    end
    if ((rx_bus.code_valid === 1'b1) && (rx_bus.frame_err === 1'b1)) begin
      both_total <= both_total + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic model_reset();
    m_code = 8'h00;
    m_isb  = 1'b0;
    m_ise  = 1'b0;
    m_brk  = 1'b0;
    m_ext  = 1'b0;
  endtask

  // One PS/2 bit: data set during the high phase, then a low phase; optional short low glitch.
  task automatic drive_bit(input logic b, input bit glitch);
    PS2_DAT = b;
    if (glitch) begin
      cycles(4);
      PS2_CLK = 1'b0;
      cycles(FILTER_LEN - 1);
      PS2_CLK = 1'b1;
      cycles(HALF - 4 - (FILTER_LEN - 1));
    end else begin
      cycles(HALF);
    end
    PS2_CLK = 1'b0;
    t_fall  = $time;
    cycles(HALF);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] frame, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      drive_bit(frame[i], glitch && ((i == 3) || (i == 6)));
    end
  endtask

  task automatic check_outputs(input string tag, input int dcv, input int dfe, input int ecv, input int efe);
    check($sformatf("%s.valid_count", tag), 32'(dcv), 32'(ecv));
    check($sformatf("%s.err_count", tag), 32'(dfe), 32'(efe));
    check($sformatf("%s.code", tag), 32'(rx_bus.code), 32'(m_code));
    check($sformatf("%s.is_break", tag), 32'(rx_bus.is_break), 32'(m_isb));
    check($sformatf("%s.is_extended", tag), 32'(rx_bus.is_extended), 32'(m_ise));
  endtask

  // Full frame; the model decides delivery from the bit counts on the wire.
  task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                            input bit glitch, input string tag);
    logic par;
    logic stop;
    int   cv0;
    int   fe0;
    int   ecv;
    int   efe;
    bit   ok;
    par  = (($countones(data) % 2) == 0) ? 1'b1 : 1'b0;
    if (bad_par) par = ~par;
    stop = bad_stop ? 1'b0 : 1'b1;
    cv0  = cv_total;
    fe0  = fe_total;
    send_bits({stop, par, data, 1'b0}, 11, glitch);
    PS2_DAT = 1'b1;
    cycles(5);
    ok  = (stop == 1'b1) && ((($countones(data) + ((par == 1'b1) ? 1 : 0)) % 2) == 1);
    ecv = 0;
    efe = 0;
    if (!ok) begin
      efe   = 1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (data == 8'hE0) begin
      m_ext = 1'b1;
    end else if (data == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      m_code = data;
      m_isb  = m_brk;
      m_ise  = m_ext;
      ecv    = 1;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
    end
    check_outputs(tag, cv_total - cv0, fe_total - fe0, ecv, efe);
  endtask

  int cv0;
  int fe0;

  initial begin
    reset   = 1'b1;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    model_reset();
    cycles(5);
    reset = 1'b0;
    cycles(3);
    check("reset.code", 32'(rx_bus.code), 32'h0);
    check("reset.code_valid", 32'(rx_bus.code_valid), 32'h0);
    check("reset.is_break", 32'(rx_bus.is_break), 32'h0);
    check("reset.is_extended", 32'(rx_bus.is_extended), 32'h0);
    check("reset.frame_err", 32'(rx_bus.frame_err), 32'h0);

    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, "make_1c");
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, "brk_f0");
    send_frame(8'h23, 1'b0, 1'b0, 1'b0, "brk_23");
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0, "xb_e0");
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, "xb_f0");
    send_frame(8'h75, 1'b0, 1'b0, 1'b0, "xb_75");
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, "make_5a");

    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, "bad_parity");
    check("err_latency", 32'((t_fe - t_fall) / 10), 32'(FILTER_LEN + 3));
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, "bad_stop");
    send_frame(8'h23, 1'b0, 1'b0, 1'b0, "recover_23");

    // Stalled frame after 4 data bits; the pending E0 must be dropped.
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0, "to_e0");
    cv0 = cv_total;
    fe0 = fe_total;
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5, 1'b0);
    cycles(TIMEOUT_CYCLES + 10);
    m_ext = 1'b0;
    m_brk = 1'b0;
    check_outputs("timeout", cv_total - cv0, fe_total - fe0, 0, 1);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, "after_timeout");

    // Reset after 6 data bits; the pending F0 and held code are lost.
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, "rst_f0");
    cv0 = cv_total;
    fe0 = fe_total;
    send_bits({1'b1, 1'b0, 8'h23, 1'b0}, 7, 1'b0);
    reset = 1'b1;
    cycles(2);
    reset   = 1'b0;
    PS2_DAT = 1'b1;
    cycles(5);
    model_reset();
    check_outputs("mid_reset", cv_total - cv0, fe_total - fe0, 0, 0);
    send_frame(8'h23, 1'b0, 1'b0, 1'b0, "after_reset");

    send_frame(8'h6B, 1'b0, 1'b0, 1'b1, "glitch");
    check("valid_latency", 32'((t_cv - t_fall) / 10), 32'(FILTER_LEN + 3));

    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      int         kind;
      kind = int'($urandom_range(0, 9));
      if (kind < 2) d = 8'hE0;
      else if (kind < 4) d = 8'hF0;
      else d = 8'($urandom_range(0, 255));
      send_frame(d, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0, $sformatf("rand%0d", n));
    end

    check("strobe_overlap", 32'(both_total), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
